// File: rtl/mul_flag_unit.sv
// Iterative shift-add multiply / multiply-accumulate unit (MUL, MLA, MULS, MLAS).
// Drives the result, the NZCV flag nibble and the flag-write enables for the flag register.
module mul_flag_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] src_acc,
   input  logic             accumulate,
   input  logic             set_flags,
   input  logic             cond_pass,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_we,
   output logic [3:0]       alu_flags,
   output logic [1:0]       flag_write
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] prod_q;
   logic [WIDTH-1:0] prod_d;
   logic [WIDTH-1:0] result_q;
   logic [CNT_W-1:0] cnt_q;
   logic             set_flags_q;
   logic             cond_pass_q;
   logic             done_q;
   logic             we_q;
   logic [1:0]       fw_q;
   logic [3:0]       flags_q;
   logic             last_iter;

   // One shift-add step; the carry out of the top bit is intentionally dropped.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path can infer a latch.
      prod_d = prod_q;
      if (mplier_q[0]) begin
         prod_d = prod_q + mcand_q;
      end
   end

   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         prod_q      <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         set_flags_q <= 1'b0;
         cond_pass_q <= 1'b0;
         done_q      <= 1'b0;
         we_q        <= 1'b0;
         fw_q        <= 2'b00;
         flags_q     <= 4'b0000;
      end else begin
         // NOTE: pulse registers default low each edge, so they can only be high in the DONE cycle.
         done_q <= 1'b0;
         we_q   <= 1'b0;
         fw_q   <= 2'b00;
         if (flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     mcand_q     <= src_a;
                     mplier_q    <= src_b;
                     prod_q      <= accumulate ? src_acc : '0;
                     set_flags_q <= set_flags;
                     cond_pass_q <= cond_pass;
                     cnt_q       <= '0;
                     state_q     <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  prod_q   <= prod_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + 1'b1;
                  if (last_iter) begin
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     result_q <= prod_d;
                     flags_q  <= {prod_d[WIDTH-1], (prod_d == '0), 2'b00};
                     we_q     <= cond_pass_q;
                     fw_q     <= {set_flags_q & cond_pass_q, 1'b0};
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // A flush in the DONE cycle cancels the write-back pulses in that same cycle.
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q & ~flush;
   assign result_we  = we_q & ~flush;
   assign flag_write = fw_q & {2{~flush}};
   assign result     = result_q;
   assign alu_flags  = flags_q;

endmodule
